// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: shares one fixed-latency memory port between the
// load buffer and ROB-head committed stores. Returns load data toward the CDB
// and drops squashed speculative loads.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module dmem_port_arbiter #(
    parameter int unsigned MEM_LATENCY  = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ld_req,
    input  logic [`XLEN-1:0]        ld_addr,
    input  logic [`ROB_TAG_LEN-1:0] ld_tag,
    input  logic                    ld_spec,
    output logic                    ld_grant,
    input  logic                    st_req,
    input  logic [`XLEN-1:0]        st_addr,
    input  logic [`XLEN-1:0]        st_data,
    input  logic [1:0]              st_size,
    output logic                    st_grant,
    input  logic                    kill,
    input  logic                    resolve,
    output logic [1:0]              mem_command,
    output logic [`XLEN-1:0]        mem_addr,
    output logic [`XLEN-1:0]        mem_wdata,
    output logic [1:0]              mem_size,
    input  logic [`XLEN-1:0]        mem_rdata,
    input  logic                    cdb_stall,
    output logic                    ld_done,
    output logic [`ROB_TAG_LEN-1:0] ld_done_tag,
    output logic [`XLEN-1:0]        ld_done_data,
    output logic                    busy
);

    localparam int unsigned LatW = $clog2(MEM_LATENCY + 1);
    localparam int unsigned StvW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {StIdle, StLdWait, StStWait, StLdResp} state_e;

    state_e                  state_q, state_d;
    logic [LatW-1:0]         lat_cnt_q, lat_cnt_d;
    logic [StvW-1:0]         starve_cnt_q, starve_cnt_d;
    logic [`ROB_TAG_LEN-1:0] tag_q, tag_d;
    logic [`XLEN-1:0]        data_q, data_d;
    logic                    spec_q, spec_d;
    logic                    squash_q, squash_d;

    logic arb_open;
    logic ld_ok;
    logic starved;
    logic kill_held;
    logic lat_last;

    // Arbitration is blocked during reset so nothing is issued while it is asserted.
    assign arb_open  = (state_q == StIdle) && !reset;
    assign ld_ok     = ld_req && !(kill && ld_spec);
    assign starved   = (starve_cnt_q == StvW'(STARVE_LIMIT));
    assign kill_held = kill && spec_q;
    assign lat_last  = (lat_cnt_q == LatW'(1));
    assign busy      = (state_q != StIdle);

    // Grant decision: store first, unless the waiting load has been starved.
    always_comb begin
        st_grant = arb_open && st_req && !(ld_ok && starved);
        ld_grant = arb_open && ld_ok && !st_grant;
    end

    // Bus command is driven only in the grant (issue) cycle.
    always_comb begin
        mem_command = 2'd0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_size    = 2'd0;
        if (st_grant) begin
            mem_command = 2'd2;
            mem_addr    = st_addr;
            mem_wdata   = st_data;
            mem_size    = st_size;
        end else if (ld_grant) begin
            mem_command = 2'd1;
            mem_addr    = ld_addr;
            mem_size    = 2'd2;
        end
    end

    // Load result toward the CDB; a kill of a speculative result suppresses it at once.
    always_comb begin
        ld_done      = (state_q == StLdResp) && !kill_held && !reset;
        ld_done_tag  = ld_done ? tag_q : '0;
        ld_done_data = ld_done ? data_q : '0;
    end

    // Next-state logic for the access FSM, held load and starvation counter.
    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        tag_d        = tag_q;
        data_d       = data_q;
        spec_d       = spec_q;
        squash_d     = squash_q;

        if (!ld_req || ld_grant) begin
            starve_cnt_d = '0;
        end else if (st_grant && !starved) begin
            starve_cnt_d = starve_cnt_q + StvW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (ld_grant) begin
                    state_d   = StLdWait;
                    tag_d     = ld_tag;
                    spec_d    = ld_spec && !resolve;
                    squash_d  = 1'b0;
                    lat_cnt_d = LatW'(MEM_LATENCY);
                end else if (st_grant) begin
                    state_d   = StStWait;
                    lat_cnt_d = LatW'(MEM_LATENCY);
                end
            end
            StLdWait: begin
                lat_cnt_d = lat_cnt_q - LatW'(1);
                if (kill_held) begin
                    squash_d = 1'b1;
                end else if (resolve) begin
                    spec_d = 1'b0;
                end
                // The bus access cannot be aborted; a squashed load just skips the response.
                if (lat_last) begin
                    if (squash_q || kill_held) begin
                        state_d = StIdle;
                    end else begin
                        data_d  = mem_rdata;
                        state_d = StLdResp;
                    end
                end
            end
            StStWait: begin
                lat_cnt_d = lat_cnt_q - LatW'(1);
                if (lat_last) begin
                    state_d = StIdle;
                end
            end
            StLdResp: begin
                if (kill_held) begin
                    state_d = StIdle;
                end else begin
                    if (resolve) begin
                        spec_d = 1'b0;
                    end
                    if (!cdb_stall) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            tag_q        <= '0;
            data_q       <= '0;
            spec_q       <= 1'b0;
            squash_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            spec_q       <= spec_d;
            squash_q     <= squash_d;
        end
    end

endmodule
